// File: rtl/rotary_addr_sel.sv
// rotary_addr_sel: quadrature detent decoder driving four per-bank wrap-around
// address counters; the counter of the bank chosen by the switches is shown on
// addr, and every completed detent produces a one-cycle step_up/step_dn pulse.
// Optional feature macro: ROT_CLEAR_EN (push-button clears the selected bank).
module rotary_addr_sel #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          DIR_INVERT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rot_a,
  input  logic                  rot_b,
  input  logic                  rot_ctr,
  input  logic [1:0]            bank,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  step_up,
  output logic                  step_dn
);

  localparam int unsigned NUM_BANKS = 4;

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_CW1,
    S_CW2,
    S_CW3,
    S_CCW1,
    S_CCW2,
    S_CCW3
  } state_t;

  logic [1:0]            r_q_meta;
  logic [1:0]            r_q_sync;
  state_t                r_state;
  state_t                w_next;
  logic                  w_cw_done;
  logic                  w_ccw_done;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_clr;
  logic [ADDR_WIDTH-1:0] r_cnt [NUM_BANKS];

  // Two-flop synchronizer for the encoder phases, q = {a, b}
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_meta <= 2'b00;
      r_q_sync <= 2'b00;
    end else begin
      r_q_meta <= {rot_a, rot_b};
      r_q_sync <= r_q_meta;
    end
  end

`ifdef ROT_CLEAR_EN
  logic r_ctr_meta;
  logic r_ctr_sync;
  logic r_ctr_prev;

  // Synchronize the push-button and keep its previous value for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr_meta <= 1'b0;
      r_ctr_sync <= 1'b0;
      r_ctr_prev <= 1'b0;
    end else begin
      r_ctr_meta <= rot_ctr;
      r_ctr_sync <= r_ctr_meta;
      r_ctr_prev <= r_ctr_sync;
    end
  end

  assign w_clr = r_ctr_sync & ~r_ctr_prev;
`else
  logic w_unused_ctr;

  assign w_unused_ctr = rot_ctr;
  assign w_clr        = 1'b0;
`endif

  // Decoder state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: follow the Gray path forward/back, any two-bit jump resyncs via WAIT
  always_comb begin
    w_next     = r_state;
    w_cw_done  = 1'b0;
    w_ccw_done = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (r_q_sync == 2'b00) w_next = S_IDLE;
      end
      S_IDLE: begin
        case (r_q_sync)
          2'b10:   w_next = S_CW1;
          2'b01:   w_next = S_CCW1;
          2'b11:   w_next = S_WAIT;
          default: w_next = S_IDLE;
        endcase
      end
      S_CW1: begin
        case (r_q_sync)
          2'b11:   w_next = S_CW2;
          2'b00:   w_next = S_IDLE;
          2'b10:   w_next = S_CW1;
          default: w_next = S_WAIT;
        endcase
      end
      S_CW2: begin
        case (r_q_sync)
          2'b01:   w_next = S_CW3;
          2'b10:   w_next = S_CW1;
          2'b11:   w_next = S_CW2;
          default: w_next = S_WAIT;
        endcase
      end
      S_CW3: begin
        case (r_q_sync)
          2'b00: begin
            w_next    = S_IDLE;
            w_cw_done = 1'b1;
          end
          2'b11:   w_next = S_CW2;
          2'b01:   w_next = S_CW3;
          default: w_next = S_WAIT;
        endcase
      end
      S_CCW1: begin
        case (r_q_sync)
          2'b11:   w_next = S_CCW2;
          2'b00:   w_next = S_IDLE;
          2'b01:   w_next = S_CCW1;
          default: w_next = S_WAIT;
        endcase
      end
      S_CCW2: begin
        case (r_q_sync)
          2'b10:   w_next = S_CCW3;
          2'b01:   w_next = S_CCW1;
          2'b11:   w_next = S_CCW2;
          default: w_next = S_WAIT;
        endcase
      end
      S_CCW3: begin
        case (r_q_sync)
          2'b00: begin
            w_next     = S_IDLE;
            w_ccw_done = 1'b1;
          end
          2'b11:   w_next = S_CCW2;
          2'b10:   w_next = S_CCW3;
          default: w_next = S_WAIT;
        endcase
      end
      default: w_next = S_WAIT;
    endcase
  end

  assign w_inc = DIR_INVERT ? w_ccw_done : w_cw_done;
  assign w_dec = DIR_INVERT ? w_cw_done  : w_ccw_done;

  // Per-bank counters; a clear of the selected bank overrides a coincident step
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_clr) begin
      r_cnt[bank] <= '0;
    end else if (w_inc) begin
      r_cnt[bank] <= r_cnt[bank] + ADDR_WIDTH'(1);
    end else if (w_dec) begin
      r_cnt[bank] <= r_cnt[bank] - ADDR_WIDTH'(1);
    end
  end

  // Step pulses, aligned with the counter update
  always_ff @(posedge clk) begin
    if (rst) begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      step_up <= w_inc & ~w_clr;
      step_dn <= w_dec & ~w_clr;
    end
  end

  assign addr = r_cnt[bank];

endmodule

// File: tb/tb_rotary_addr_sel.sv
// Bench for rotary_addr_sel: detent-level vector table, hand-written latency,
// reset and clear sequences, and random detent traffic against a bank model.
module tb_rotary_addr_sel;

  localparam int unsigned AW  = 5;
  localparam int          MOD = 32;

  localparam int OP_CW    = 0;
  localparam int OP_CCW   = 1;
  localparam int OP_READ  = 2;
  localparam int OP_INV   = 3;
  localparam int OP_JITCW = 4;
  localparam int OP_BKCCW = 5;

  logic          clk;
  logic          rst;
  logic          rot_a;
  logic          rot_b;
  logic          rot_ctr;
  logic [1:0]    bank;
  logic [AW-1:0] addr;
  logic          step_up;
  logic          step_dn;

  int n_assert;
  int n_fail;
  int up_cnt;
  int dn_cnt;
  int both_cnt;
  int model [4];

  typedef struct {
    int op;
    int bnk;
    int exp_addr;
    int exp_up;
    int exp_dn;
  } vec_t;

  vec_t vecs [12];

  rotary_addr_sel #(.ADDR_WIDTH(AW), .DIR_INVERT(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .rot_a   (rot_a),
    .rot_b   (rot_b),
    .rot_ctr (rot_ctr),
    .bank    (bank),
    .addr    (addr),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_up) up_cnt++;
    if (step_dn) dn_cnt++;
    if (step_up && step_dn) both_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] q, input int n);
    rot_a = q[1];
    rot_b = q[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 0;
    drive(2'b00, 4);
  endtask

  // Apply one detent-level operation; always ends with q at 00 for 4 cycles
  task automatic do_op(input int op);
    case (op)
      OP_CW:    begin drive(2'b10, 4); drive(2'b11, 4); drive(2'b01, 4); drive(2'b00, 4); end
      OP_CCW:   begin drive(2'b01, 4); drive(2'b11, 4); drive(2'b10, 4); drive(2'b00, 4); end
      OP_INV:   begin drive(2'b11, 4); drive(2'b00, 4); end
      OP_JITCW: begin
        drive(2'b10, 4); drive(2'b00, 4); drive(2'b10, 4);
        drive(2'b11, 4); drive(2'b01, 4); drive(2'b00, 4);
      end
      OP_BKCCW: begin
        drive(2'b01, 4); drive(2'b11, 4); drive(2'b01, 4); drive(2'b11, 4);
        drive(2'b10, 4); drive(2'b00, 4);
      end
      default:  drive(2'b00, 4);
    endcase
  endtask

  // Detent-level reference: CW adds one, CCW subtracts one, modulo 2^AW
  function automatic int model_delta(input int op);
    if (op == OP_CW || op == OP_JITCW) return 1;
    if (op == OP_CCW || op == OP_BKCCW) return -1;
    return 0;
  endfunction

  task automatic run_op(input string tag, input int op, input int bnk,
                        input int exp_addr, input int exp_up, input int exp_dn);
    int u0;
    int d0;
    bank = 2'(bnk);
    u0 = up_cnt;
    d0 = dn_cnt;
    do_op(op);
    chk({tag, "_addr"}, int'(addr), exp_addr);
    chk({tag, "_up"}, up_cnt - u0, exp_up);
    chk({tag, "_dn"}, dn_cnt - d0, exp_dn);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    up_cnt   = 0;
    dn_cnt   = 0;
    both_cnt = 0;
    rst      = 1'b1;
    rot_a    = 1'b0;
    rot_b    = 1'b0;
    rot_ctr  = 1'b0;
    bank     = 2'd0;

    vecs[0]  = '{OP_CW,    0, 1,  1, 0};
    vecs[1]  = '{OP_CCW,   1, 31, 0, 1};
    vecs[2]  = '{OP_READ,  0, 1,  0, 0};
    vecs[3]  = '{OP_INV,   0, 1,  0, 0};
    vecs[4]  = '{OP_CW,    0, 2,  1, 0};
    vecs[5]  = '{OP_JITCW, 3, 1,  1, 0};
    vecs[6]  = '{OP_CCW,   3, 0,  0, 1};
    vecs[7]  = '{OP_CCW,   3, 31, 0, 1};
    vecs[8]  = '{OP_READ,  1, 31, 0, 0};
    vecs[9]  = '{OP_CW,    1, 0,  1, 0};
    vecs[10] = '{OP_READ,  2, 0,  0, 0};
    vecs[11] = '{OP_BKCCW, 2, 31, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset_addr", int'(addr), 0);
    chk("reset_up", int'(step_up), 0);
    chk("reset_dn", int'(step_dn), 0);
    rst = 1'b0;
    drive(2'b00, 4);

    // Latency: pulse and count appear after the third edge following 00
    bank = 2'd0;
    drive(2'b10, 4);
    drive(2'b11, 4);
    drive(2'b01, 4);
    rot_a = 1'b0;
    rot_b = 1'b0;
    @(negedge clk);
    chk("lat_e1_up", int'(step_up), 0);
    @(negedge clk);
    chk("lat_e2_up", int'(step_up), 0);
    chk("lat_e2_addr", int'(addr), 0);
    @(negedge clk);
    chk("lat_e3_up", int'(step_up), 1);
    chk("lat_e3_addr", int'(addr), 1);
    @(negedge clk);
    chk("lat_e4_up", int'(step_up), 0);
    drive(2'b00, 2);

    // Vector table, starting from a fresh reset
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].bnk,
             vecs[i].exp_addr, vecs[i].exp_up, vecs[i].exp_dn);
    end

    // 32 CW detents on bank 2 wrap all the way round
    begin
      int u0;
      bank = 2'd2;
      u0 = up_cnt;
      for (int i = 0; i < 32; i++) do_op(OP_CW);
      chk("wrap32_addr", int'(addr), 31);
      chk("wrap32_up", up_cnt - u0, 32);
    end

    // Reset in CW2 with q held 11: no step, then a clean detent counts
    do_reset();
    bank = 2'd0;
    drive(2'b10, 4);
    drive(2'b11, 4);
    begin
      int u0;
      u0 = up_cnt;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive(2'b11, 6);
      chk("rstmid_addr", int'(addr), 0);
      drive(2'b00, 4);
      chk("rstmid_up", up_cnt - u0, 0);
      do_op(OP_CW);
      chk("rstmid_after_addr", int'(addr), 1);
      chk("rstmid_after_up", up_cnt - u0, 1);
    end

    // Random detent traffic against the per-bank model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int op;
      int b;
      int d;
      op = int'($urandom_range(0, 5));
      b  = int'($urandom_range(0, 3));
      d  = model_delta(op);
      model[b] = (model[b] + d + MOD) % MOD;
      run_op($sformatf("rnd%0d", i), op, b, model[b],
             (d > 0) ? 1 : 0, (d < 0) ? 1 : 0);
    end
    for (int b = 0; b < 4; b++) begin
      bank = 2'(b);
      @(negedge clk);
      chk($sformatf("rnd_bank%0d", b), int'(addr), model[b]);
    end

`ifdef ROT_CLEAR_EN
    // Push-button clear, alone and coincident with a completing step
    do_reset();
    bank = 2'd3;
    for (int i = 0; i < 5; i++) do_op(OP_CW);
    chk("clr_pre_addr", int'(addr), 5);
    begin
      int u0;
      u0 = up_cnt;
      rot_ctr = 1'b1;
      drive(2'b00, 4);
      chk("clr_addr", int'(addr), 0);
      rot_ctr = 1'b0;
      drive(2'b00, 4);
      for (int i = 0; i < 5; i++) do_op(OP_CW);
      u0 = up_cnt;
      drive(2'b10, 4);
      drive(2'b11, 4);
      drive(2'b01, 4);
      rot_ctr = 1'b1;
      drive(2'b00, 4);
      chk("clr_coinc_addr", int'(addr), 0);
      chk("clr_coinc_up", up_cnt - u0, 0);
      rot_ctr = 1'b0;
      drive(2'b00, 4);
    end
`endif

    chk("never_both", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
